// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/redirect requests in, stage stop/clear controls out.
// The slave modport is the controller side; master is the pipeline side.
interface pipe_ctrl_if;
    logic        branch_flag;
    logic        branch_num;
    logic        ex2_num;
    logic        mem_req;
    logic        mem_ready;
    logic        load_use;
    logic        fe_stop;
    logic        buf_flush;
    logic        deex_stop;
    logic        deex_rst;
    logic        exwb_stop;
    logic        exwb_rst;
    logic        ex2_kill;
    logic        mem_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;

    modport master (
        output branch_flag, branch_num, ex2_num, mem_req, mem_ready, load_use,
        input  fe_stop, buf_flush, deex_stop, deex_rst, exwb_stop, exwb_rst,
               ex2_kill, mem_timeout, ctrl_state, perf_stall, perf_flush
    );

    modport slave (
        input  branch_flag, branch_num, ex2_num, mem_req, mem_ready, load_use,
        output fe_stop, buf_flush, deex_stop, deex_rst, exwb_stop, exwb_rst,
               ex2_kill, mem_timeout, ctrl_state, perf_stall, perf_flush
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Dual-issue pipeline controller: redirect flush, memory-wait stall with timeout, load-use bubble.
// Define PIPE_CTRL_PERF_EN to enable the perf_stall/perf_flush event counters.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_FLUSH   = 2'b01,
        ST_MEMWAIT = 2'b10,
        ST_HALT    = 2'b11
    } state_e;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_WAIT_MAX - 1);

    state_e     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       pend_flush_q, pend_flush_d;
    logic       timeout_q, timeout_d;

    logic ex2_kill;
    logic mem_stall;
    logic fe_stop, buf_flush, deex_stop, deex_rst, exwb_stop;

    // A killed younger EX2 op cannot hold the pipe on its memory access.
    assign ex2_kill  = (state_q == ST_RUN) & ~reset & bus.branch_flag
                     & ~bus.branch_num & bus.ex2_num;
    assign mem_stall = bus.mem_req & ~bus.mem_ready & ~ex2_kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            flush_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            pend_flush_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            pend_flush_q <= pend_flush_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        pend_flush_d = pend_flush_q;
        timeout_d    = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d      = ST_MEMWAIT;
                    wait_cnt_d   = '0;
                    pend_flush_d = bus.branch_flag;
                end else if (bus.branch_flag) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q + 3'd1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                // A ready response in the would-be timeout cycle still completes normally.
                if (bus.mem_ready) begin
                    if (pend_flush_q) begin
                        state_d      = ST_FLUSH;
                        flush_cnt_d  = '0;
                        pend_flush_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    if (wait_cnt_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        fe_stop   = 1'b0;
        buf_flush = 1'b0;
        deex_stop = 1'b0;
        deex_rst  = 1'b0;
        exwb_stop = 1'b0;
        if (reset) begin
            buf_flush = 1'b1;
            deex_rst  = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        fe_stop   = 1'b1;
                        deex_stop = 1'b1;
                        exwb_stop = 1'b1;
                    end else if (bus.branch_flag) begin
                        buf_flush = 1'b1;
                        deex_rst  = 1'b1;
                    end else if (bus.load_use) begin
                        fe_stop  = 1'b1;
                        deex_rst = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    deex_rst = 1'b1;
                end
                ST_MEMWAIT: begin
                    if (bus.mem_ready) begin
                        buf_flush = pend_flush_q;
                        deex_rst  = pend_flush_q;
                    end else begin
                        fe_stop   = 1'b1;
                        deex_stop = 1'b1;
                        exwb_stop = 1'b1;
                    end
                end
                default: begin
                    fe_stop   = 1'b1;
                    deex_stop = 1'b1;
                    exwb_stop = 1'b1;
                end
            endcase
        end
    end

    assign bus.fe_stop     = fe_stop;
    assign bus.buf_flush   = buf_flush;
    assign bus.deex_stop   = deex_stop;
    assign bus.deex_rst    = deex_rst;
    assign bus.exwb_stop   = exwb_stop;
    assign bus.exwb_rst    = reset;
    assign bus.ex2_kill    = ex2_kill;
    assign bus.mem_timeout = timeout_q;
    assign bus.ctrl_state  = state_q;

`ifdef PIPE_CTRL_PERF_EN
    // Index 0 counts fetch-stall cycles, index 1 counts non-reset buffer flushes.
    logic [1:0] perf_evt;
    assign perf_evt = {buf_flush & ~reset, fe_stop};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_perf
        logic [31:0] cnt_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (perf_evt[gi]) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall = g_perf[0].cnt_q;
    assign bus.perf_flush = g_perf[1].cnt_q;
`else
    assign bus.perf_stall = '0;
    assign bus.perf_flush = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed redirect/stall/timeout scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;
    localparam int FC  = 1;
    localparam int MWM = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.FLUSH_CYCLES(FC), .MEM_WAIT_MAX(MWM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model: mode 0=run 1=bubbles 2=waiting on memory 3=dead until reset
    int          m_mode      = 0;
    int          m_flush_left = 0;
    int          m_waited    = 0;
    bit          m_pend      = 1'b0;
    bit          m_to        = 1'b0;
    bit          m_valid     = 1'b0;
    logic [31:0] m_ps        = '0;
    logic [31:0] m_pf        = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit bf, input bit bn, input bit en,
                        input bit mr, input bit rdy, input bit lu);
        bit e_fe, e_bf, e_ds, e_dr, e_es, e_er, e_kill, kill, stall;
        int n_mode, n_fl, n_w;
        bit n_pend, n_to;
        logic [31:0] n_ps, n_pf;

        reset = rst;
        bus.branch_flag = bf;
        bus.branch_num  = bn;
        bus.ex2_num     = en;
        bus.mem_req     = mr;
        bus.mem_ready   = rdy;
        bus.load_use    = lu;
        @(negedge clk);

        {e_fe, e_bf, e_ds, e_dr, e_es, e_er, e_kill} = '0;
        n_mode = m_mode; n_fl = m_flush_left; n_w = m_waited;
        n_pend = m_pend; n_to = m_to; n_ps = m_ps; n_pf = m_pf;
        if (rst) begin
            e_bf = 1; e_dr = 1; e_er = 1;
            n_mode = 0; n_fl = 0; n_w = 0; n_pend = 0; n_to = 0; n_ps = '0; n_pf = '0;
        end else begin
            case (m_mode)
                0: begin
                    kill   = bf && !bn && en;
                    stall  = mr && !rdy && !kill;
                    e_kill = kill;
                    if (stall) begin
                        e_fe = 1; e_ds = 1; e_es = 1;
                        n_mode = 2; n_w = 0; n_pend = bf;
                    end else if (bf) begin
                        e_bf = 1; e_dr = 1;
                        n_mode = 1; n_fl = FC;
                    end else if (lu) begin
                        e_fe = 1; e_dr = 1;
                    end
                end
                1: begin
                    e_dr = 1;
                    n_fl = m_flush_left - 1;
                    if (n_fl == 0) n_mode = 0;
                end
                2: begin
                    if (rdy) begin
                        if (m_pend) begin
                            e_bf = 1; e_dr = 1;
                            n_mode = 1; n_fl = FC; n_pend = 0;
                        end else begin
                            n_mode = 0;
                        end
                    end else begin
                        e_fe = 1; e_ds = 1; e_es = 1;
                        n_w = m_waited + 1;
                        if (n_w == MWM) begin
                            n_to = 1; n_mode = 3;
                        end
                    end
                end
                default: begin
                    e_fe = 1; e_ds = 1; e_es = 1;
                end
            endcase
            if (e_fe) n_ps = m_ps + 32'd1;
            if (e_bf) n_pf = m_pf + 32'd1;
        end

        check_eq("fe_stop",   32'(bus.fe_stop),   32'(e_fe));
        check_eq("buf_flush", 32'(bus.buf_flush), 32'(e_bf));
        check_eq("deex_stop", 32'(bus.deex_stop), 32'(e_ds));
        check_eq("deex_rst",  32'(bus.deex_rst),  32'(e_dr));
        check_eq("exwb_stop", 32'(bus.exwb_stop), 32'(e_es));
        check_eq("exwb_rst",  32'(bus.exwb_rst),  32'(e_er));
        check_eq("ex2_kill",  32'(bus.ex2_kill),  32'(e_kill));
        if (m_valid) begin
            check_eq("ctrl_state",  32'(bus.ctrl_state),  32'(m_mode));
            check_eq("mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
`ifdef PIPE_CTRL_PERF_EN
            check_eq("perf_stall", bus.perf_stall, m_ps);
            check_eq("perf_flush", bus.perf_flush, m_pf);
`else
            check_eq("perf_stall_tie", bus.perf_stall, 32'd0);
            check_eq("perf_flush_tie", bus.perf_flush, 32'd0);
`endif
        end
        $display("t=%0t rst=%0b bf=%0b bn=%0b en=%0b mr=%0b rdy=%0b lu=%0b | st=%0d fe=%0b bfl=%0b ds=%0b dr=%0b es=%0b er=%0b kill=%0b to=%0b",
                 $time, rst, bf, bn, en, mr, rdy, lu, bus.ctrl_state, bus.fe_stop, bus.buf_flush,
                 bus.deex_stop, bus.deex_rst, bus.exwb_stop, bus.exwb_rst, bus.ex2_kill, bus.mem_timeout);

        @(posedge clk);
        #1;
        m_mode = n_mode; m_flush_left = n_fl; m_waited = n_w;
        m_pend = n_pend; m_to = n_to; m_ps = n_ps; m_pf = n_pf;
        if (rst) m_valid = 1'b1;
    endtask

    initial begin
        int halt_run;
        reset = 1'b1;
        bus.branch_flag = 0; bus.branch_num = 0; bus.ex2_num = 0;
        bus.mem_req = 0; bus.mem_ready = 0; bus.load_use = 0;

        // reset, then idle
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // redirect with single bubble
        step(0, 1, 0, 0, 0, 0, 0);
        check_eq("redir_flush_state", 32'(bus.ctrl_state), 32'd1);
        step(0, 1, 0, 0, 0, 0, 0);
        check_eq("redir_back_run", 32'(bus.ctrl_state), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        // kill of younger EX2 suppresses its memory stall
        step(0, 1, 0, 1, 1, 0, 0);
        check_eq("kill_to_flush", 32'(bus.ctrl_state), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // memory wait then ready
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        check_eq("memwait_exit_run", 32'(bus.ctrl_state), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        // pending flush carried through memory wait
        step(0, 1, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        check_eq("pend_to_flush", 32'(bus.ctrl_state), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);

        // ready arriving in the would-be timeout cycle wins
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < MWM - 1; i++) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        check_eq("late_ready_no_to", 32'(bus.mem_timeout), 32'd0);

        // timeout into halt, then recovery by reset
        for (int i = 0; i < MWM + 1; i++) step(0, 0, 0, 0, 1, 0, 0);
        check_eq("timeout_halt", 32'(bus.ctrl_state), 32'd3);
        check_eq("timeout_flag", 32'(bus.mem_timeout), 32'd1);
        step(0, 1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        check_eq("reset_run", 32'(bus.ctrl_state), 32'd0);
        check_eq("reset_flag", 32'(bus.mem_timeout), 32'd0);

        // single load-use bubble
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        halt_run = 0;
        for (int i = 0; i < 600; i++) begin
            bit r;
            r = ($urandom_range(0, 59) == 0) || (halt_run > 2);
            step(r, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
            halt_run = (m_mode == 3) ? halt_run + 1 : 0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
